// File: rtl/mem_dma_pkg.sv
// Shared types for the cart-RAM DMA engine.
//   cmd_e   : command encoding presented on the cmd port
//   state_e : sequencer states
//   is_active() : true for states that hold the RAM port (busy=1)
package mem_dma_pkg;

  typedef enum logic [1:0] {
    CMD_COPY = 2'd0,
    CMD_FILL = 2'd1,
    CMD_SUM  = 2'd2,
    CMD_NOP  = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StCpRd,
    StCpWr,
    StFill,
    StSum,
    StSumLast,
    StFin
  } state_e;

  function automatic logic is_active(state_e s);
    return (s == StCpRd) || (s == StCpWr) || (s == StFill) || (s == StSum) || (s == StSumLast);
  endfunction

endpackage

// File: rtl/mem_dma.sv
// Single-channel DMA engine driving one port of the dual-port cart RAM.
// Executes COPY (2 cycles/byte), FILL (1 cycle/byte) and mod-256 SUM (1 cycle/byte + 1).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, abort      : command strobe (IDLE only), stop at next cycle boundary
//   cmd, src, dst,    : command, source/destination start addresses,
//   len, fill_val     : byte count (0 = none), fill byte; latched on start
//   busy, done, sum   : in-progress flag, completion pulse, last SUM result
//   mem_addr, mem_di, : RAM address, write data, write enable
//   mem_we, mem_do    : mem_do is the RAM's registered read data (1-cycle latency)
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    cmd,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] sum,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_di,
  output logic          mem_we,
  input  logic [DW-1:0] mem_do
);

  state_e        state_q, state_d;
  cmd_e          cmd_q, cmd_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d, cnt_q, cnt_d;
  logic [DW-1:0] fill_q, fill_d, acc_q, acc_d, sum_q, sum_d, di_q, di_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d, busy_q, busy_d, done_q, done_d, vld_q, vld_d;
  logic          last;

  assign last = (cnt_q == AW'(1));

  // Sequencer and pointer/counter next-state.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cmd_d  = cmd_e'(cmd);
          src_d  = src;
          dst_d  = dst;
          cnt_d  = len;
          fill_d = fill_val;
          if (len == '0) begin
            state_d = StFin;
          end else begin
            case (cmd_e'(cmd))
              CMD_COPY: state_d = StCpRd;
              CMD_FILL: state_d = StFill;
              CMD_SUM:  state_d = StSum;
              default:  state_d = StFin;
            endcase
          end
        end
      end
      StCpRd: state_d = StCpWr;
      StCpWr: begin
        src_d   = src_q + AW'(1);
        dst_d   = dst_q + AW'(1);
        cnt_d   = cnt_q - AW'(1);
        state_d = last ? StFin : StCpRd;
      end
      StFill: begin
        dst_d   = dst_q + AW'(1);
        cnt_d   = cnt_q - AW'(1);
        state_d = last ? StFin : StFill;
      end
      StSum: begin
        src_d   = src_q + AW'(1);
        cnt_d   = cnt_q - AW'(1);
        state_d = last ? StSumLast : StSum;
      end
      StSumLast: state_d = StFin;
      StFin:     state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    // The access already on the port this cycle still completes; nothing new is issued.
    if (abort && is_active(state_q)) begin
      state_d = StFin;
    end
  end

  // Accumulator, result and registered RAM-port values for the state being entered.
  always_comb begin
    // A read address was on the port this cycle, so its data arrives next cycle.
    vld_d = (state_q == StSum);
    acc_d = acc_q;
    if ((state_q == StIdle) && start) begin
      acc_d = '0;
    end else if (vld_q) begin
      acc_d = acc_q + mem_do;
    end
    sum_d = sum_q;
    if ((state_d == StFin) && (cmd_d == CMD_SUM)) begin
      sum_d = acc_d;
    end
    addr_d = '0;
    we_d   = 1'b0;
    di_d   = '0;
    case (state_d)
      StCpRd, StSum: addr_d = src_d;
      StCpWr: begin
        addr_d = dst_d;
        we_d   = 1'b1;
      end
      StFill: begin
        addr_d = dst_d;
        we_d   = 1'b1;
        di_d   = fill_d;
      end
      default: ;
    endcase
    busy_d = is_active(state_d);
    done_d = (state_d == StFin);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cmd_q   <= CMD_NOP;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      vld_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      di_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      di_q    <= di_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign mem_addr = addr_q;
  assign mem_we   = we_q;
  // During a copy write the byte comes straight from the RAM's own output register; registering
  // it here would cost a third cycle per byte. No host-side input reaches the RAM port.
  assign mem_di   = (state_q == StCpWr) ? mem_do : di_q;

endmodule

// File: tb/tb_mem_dma.sv
// Bench for mem_dma: dual-port RAM model (port A host, port B DMA), directed commands,
// scoreboard queues filled by stimulus and drained by a negedge monitor.
module tb_mem_dma;
  import mem_dma_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort;
  logic [1:0]  cmd;
  logic [15:0] src, dst, len;
  logic [7:0]  fill_val;
  logic        busy, done, mem_we;
  logic [7:0]  sum, mem_di, mem_do;
  logic [15:0] mem_addr;

  logic [15:0] a_addr;
  logic        a_we, a_re, a_rvalid;
  logic [7:0]  a_di, a_do;

  logic [7:0]  ram [0:65535];

  mem_dma #(.AW(16), .DW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .cmd      (cmd),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .fill_val (fill_val),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .mem_addr (mem_addr),
    .mem_di   (mem_di),
    .mem_we   (mem_we),
    .mem_do   (mem_do)
  );

  // Dual-port RAM with registered read on both ports.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_di;
    mem_do <= ram[mem_addr];
    if (a_we) ram[a_addr] <= a_di;
    a_do     <= ram[a_addr];
    a_rvalid <= a_re;
  end

  typedef struct packed { logic [15:0] addr; logic [7:0] data; } wr_t;
  typedef struct packed { int unsigned busy_cycles; logic [7:0] sum; } dn_t;

  wr_t        wr_q[$];
  dn_t        dn_q[$];
  logic [7:0] rd_q[$];
  wr_t        wr_exp;
  dn_t        dn_exp;
  logic [7:0] rd_exp;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT writes, completes, or the host read returns.
  int unsigned busy_cnt = 0;
  logic        done_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt  = 0;
      done_prev = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                   mem_addr, mem_di);
        end else begin
          wr_exp = wr_q.pop_front();
          check("wr_addr", {16'h0, mem_addr}, {16'h0, wr_exp.addr});
          check("wr_data", {24'h0, mem_di}, {24'h0, wr_exp.data});
          check("wr_while_busy", {31'h0, busy}, 32'h1);
        end
      end
      if (done) begin
        check("done_single_pulse", {31'h0, done_prev}, 32'h0);
        if (dn_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done, expected none");
        end else begin
          dn_exp = dn_q.pop_front();
          check("busy_cycles", busy_cnt, dn_exp.busy_cycles);
          check("sum", {24'h0, sum}, {24'h0, dn_exp.sum});
          check("busy_in_fin", {31'h0, busy}, 32'h0);
          check("we_in_fin", {31'h0, mem_we}, 32'h0);
        end
        busy_cnt = 0;
      end
      done_prev = done;
      if (a_rvalid) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: got 0x%0h, expected none", a_do);
        end else begin
          rd_exp = rd_q.pop_front();
          check("ram_readback", {24'h0, a_do}, {24'h0, rd_exp});
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic host_wr(input logic [15:0] a, input logic [7:0] d);
    a_addr = a; a_di = d; a_we = 1'b1;
    cyc();
    a_we = 1'b0;
  endtask

  task automatic host_rd(input logic [15:0] a, input logic [7:0] exp);
    a_addr = a; a_re = 1'b1;
    rd_q.push_back(exp);
    cyc();
    a_re = 1'b0;
  endtask

  task automatic issue(input logic [1:0] c, input logic [15:0] s, input logic [15:0] d,
                       input logic [15:0] l, input logic [7:0] f);
    cmd = c; src = s; dst = d; len = l; fill_val = f; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic push_dn(input int unsigned b, input logic [7:0] s);
    dn_t e;
    e.busy_cycles = b; e.sum = s;
    dn_q.push_back(e);
  endtask

  task automatic wait_done(input int max);
    bit got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wait_done: no done within %0d cycles, expected done", max);
    end
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cmd = '0; src = '0; dst = '0; len = '0;
    fill_val = '0; a_addr = '0; a_we = 1'b0; a_re = 1'b0; a_di = '0;
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_sum", {24'h0, sum}, 32'h0);
    check("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
    check("rst_mem_di", {24'h0, mem_di}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    cyc();

    // Preload through the host port.
    host_wr(16'h1004, 8'h77);
    for (int i = 0; i < 4; i++) host_wr(16'(i), 8'(i + 1));
    host_wr(16'hFFFE, 8'hFF);
    host_wr(16'hFFFF, 8'h01);
    host_wr(16'h2000, 8'h55);
    host_wr(16'h4000, 8'h44);
    host_wr(16'h500A, 8'hBB);
    for (int i = 0; i < 4; i++) host_wr(16'h6000 + 16'(i), 8'hC0 + 8'(i));
    host_wr(16'h7001, 8'hEE);

    // FILL 0x1000..0x1003 with A5.
    for (int i = 0; i < 4; i++) push_wr(16'h1000 + 16'(i), 8'hA5);
    push_dn(4, 8'h00);
    issue(CMD_FILL, 16'h0000, 16'h1000, 16'd4, 8'hA5);
    wait_done(20);
    for (int i = 0; i < 4; i++) host_rd(16'h1000 + 16'(i), 8'hA5);
    host_rd(16'h1004, 8'h77);
    cyc();

    // COPY 0x0000 -> 0x8000, 4 bytes.
    for (int i = 0; i < 4; i++) push_wr(16'h8000 + 16'(i), 8'(i + 1));
    push_dn(8, 8'h00);
    issue(CMD_COPY, 16'h0000, 16'h8000, 16'd4, 8'h00);
    wait_done(30);
    for (int i = 0; i < 4; i++) host_rd(16'h8000 + 16'(i), 8'(i + 1));
    cyc();

    // SUM across the address wrap: FF+01+10+20 = 0x130 -> 0x30.
    host_wr(16'h0000, 8'h10);
    host_wr(16'h0001, 8'h20);
    push_dn(5, 8'h30);
    issue(CMD_SUM, 16'hFFFE, 16'h0000, 16'd4, 8'h00);
    wait_done(20);

    // Forward-overlapping COPY replicates the first byte.
    for (int i = 1; i < 4; i++) push_wr(16'h2000 + 16'(i), 8'h55);
    push_dn(6, 8'h30);
    issue(CMD_COPY, 16'h2000, 16'h2001, 16'd3, 8'h00);
    wait_done(30);
    for (int i = 1; i < 4; i++) host_rd(16'h2000 + 16'(i), 8'h55);
    cyc();

    // len=0 and reserved cmd: done exactly one cycle after start, no access.
    push_dn(0, 8'h30);
    issue(CMD_FILL, 16'h0000, 16'h0100, 16'd0, 8'h12);
    wait_done(1);
    push_dn(0, 8'h30);
    issue(2'd3, 16'h0000, 16'h0200, 16'd5, 8'h34);
    wait_done(1);

    // start while busy is ignored.
    for (int i = 0; i < 4; i++) push_wr(16'h3000 + 16'(i), 8'h11);
    push_dn(4, 8'h30);
    issue(CMD_FILL, 16'h0000, 16'h3000, 16'd4, 8'h11);
    cmd = CMD_FILL; dst = 16'h4000; len = 16'd2; fill_val = 8'h22; start = 1'b1;
    cyc();
    cyc();
    start = 1'b0;
    wait_done(20);
    repeat (3) cyc();
    host_rd(16'h4000, 8'h44);
    host_rd(16'h3003, 8'h11);
    cyc();

    // FILL len=100, aborted during the 10th write.
    for (int i = 0; i < 10; i++) push_wr(16'h5000 + 16'(i), 8'h66);
    push_dn(10, 8'h30);
    issue(CMD_FILL, 16'h0000, 16'h5000, 16'd100, 8'h66);
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    cyc();
    abort = 1'b0;
    wait_done(5);
    host_rd(16'h5009, 8'h66);
    host_rd(16'h500A, 8'hBB);
    cyc();

    // Reset mid-COPY: only the first byte has been written when rst lands.
    push_wr(16'h7000, 8'hC0);
    issue(CMD_COPY, 16'h6000, 16'h7000, 16'd4, 8'h00);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    @(negedge clk);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_mem_we", {31'h0, mem_we}, 32'h0);
    check("midrst_done", {31'h0, done}, 32'h0);
    check("midrst_sum", {24'h0, sum}, 32'h0);
    cyc();
    rst = 1'b0;
    repeat (2) cyc();
    host_rd(16'h7000, 8'hC0);
    host_rd(16'h7001, 8'hEE);
    repeat (3) cyc();

    check("wr_q_drained", wr_q.size(), 32'h0);
    check("dn_q_drained", dn_q.size(), 32'h0);
    check("rd_q_drained", rd_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
